rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter REG_LEN, default brisc_pkg::REG_LEN (32), register data width in bits.
REQ-002 Parameter REG_BITS, default 5, register address width in bits.
REQ-003 Parameter NUM_REQ, default 3, number of writeback requesters; legal range 2..8.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port req_valid, input, NUM_REQ, per-requester write request.
REQ-007 Port req_addr, input, NUM_REQ x REG_BITS, per-requester destination register.
REQ-008 Port req_data, input, NUM_REQ x REG_LEN, per-requester write data.
REQ-009 Port req_ready, output, NUM_REQ, per-requester accept strobe (one-hot or zero).
REQ-010 Port wr_en, output, 1, register file write enable.
REQ-011 Port wr_addr, output, REG_BITS, register file write address.
REQ-012 Port wr_data, output, REG_LEN, register file write data.
REQ-013 Port grant_idx, output, $clog2(NUM_REQ), index of the requester accepted in the previous cycle.

Function
REQ-014 The block shall share the single register file write port among NUM_REQ requesters using round-robin arbitration.
REQ-015 A transfer shall occur on requester i in cycle N when req_valid[i] and req_ready[i] are both high at the rising edge ending cycle N.
REQ-016 req_ready shall be combinational from req_valid and the arbitration pointer, with at most one bit high per cycle.
REQ-017 req_ready[i] shall be high only if req_valid[i] is high.
REQ-018 If any req_valid bit is high, exactly one req_ready bit shall be high; there shall be no idle cycles while requests are pending.
REQ-019 Search order: the search shall start at (last_grant+1) mod NUM_REQ, proceed in increasing index with wrap-around, and grant the first valid requester found.
REQ-020 last_grant shall update to the granted index only on a transfer and shall hold otherwise.
REQ-021 Requesters shall hold valid, addr and data stable until accepted; the arbiter shall not check this.
REQ-022 Output latency: a transfer in cycle N shall present wr_en=1, wr_addr and wr_data (all registered) in cycle N+1 only.
REQ-023 A cycle with no transfer shall drive wr_en=0 in the following cycle; wr_addr and wr_data shall hold their previous values.
REQ-024 A transfer with req_addr equal to 0 shall be accepted normally and update last_grant, but shall produce wr_en=0 in cycle N+1, so that x0 stays zero.
REQ-025 Same-address requests in one cycle shall not be merged; each shall be written in arbitration order, with the last write winning in the register file.
REQ-026 grant_idx shall be registered alongside wr_en and is meaningful only when a transfer occurred in the prior cycle.
REQ-027 Fairness: with all requesters continuously valid, each shall be granted exactly once in every NUM_REQ consecutive cycles.

Reset
REQ-028 While reset is high, the block shall drive wr_en=0, wr_addr=0, wr_data=0, grant_idx=0 and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-029 Assertion of reset shall take effect immediately, independent of clk.
REQ-030 Reset asserted mid-operation shall drop any write registered but not yet presented, and no write shall appear after reset release.
REQ-031 During reset, req_ready shall reflect the reset pointer combinationally, but no transfer shall be registered.

Verification
REQ-032 Release reset, then in one cycle set req_valid=3'b111 with addr 1/2/3 and data A/B/C: req_ready=001, 010, 100 over three cycles; wr sequence (1,A), (2,B), (3,C), each one cycle after its grant.
REQ-033 Set req_valid=3'b010 alone with addr 5, data 0xDEADBEEF: req_ready[1]=1 in the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_idx=1.
REQ-034 Requester 2 writes addr 0 with data 0x1234: req_ready[2]=1; next cycle wr_en=0; last_grant becomes 2, so the next grant goes to 0 if it is valid.
REQ-035 Hold requesters 0 and 2 valid for 6 cycles: grants alternate 0,2,0,2,0,2 and requester 1 is never granted.
REQ-036 Assert reset in the cycle a transfer is accepted: wr_en stays 0 through reset and the first cycle after release; after release the next grant starts at requester 0.
REQ-037 Requesters 0 and 1 both target addr 7 with data 0x11 and 0x22 in the same cycle: two writes to addr 7 in arbitration order, final register value 0x22.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// NUM_REQ writeback requesters; one registered write per accepted request.
module rf_wb_arbiter #(
  parameter int unsigned REG_LEN  = 32,
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned NUM_REQ  = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][REG_BITS-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][REG_LEN-1:0]    req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               wr_en,
  output logic [REG_BITS-1:0]                wr_addr,
  output logic [REG_LEN-1:0]                 wr_data,
  output logic [$clog2(NUM_REQ)-1:0]         grant_idx
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          grant_found;

  // Search from the requester after the last grant, wrapping around.
  always_comb begin
    req_ready   = '0;
    sel         = last_grant;
    cand        = '0;
    grant_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        sel         = cand;
      end
    end
    if (grant_found) begin
      req_ready[sel] = 1'b1;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      grant_idx  <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else begin
      wr_en <= grant_found && (req_addr[sel] != '0);
      if (grant_found) begin
        wr_addr    <= req_addr[sel];
        wr_data    <= req_data[sel];
        grant_idx  <= sel;
        last_grant <= sel;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: grant order, write latency, x0 drop,
// fairness, async reset and same-address ordering.
module tb_rf_wb_arbiter;

  logic             clk;
  logic             reset;
  logic [2:0]       req_valid;
  logic [2:0][4:0]  req_addr;
  logic [2:0][31:0] req_data;
  logic [2:0]       req_ready;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [1:0]       grant_idx;

  logic [31:0] rf [32];
  int n_vec;
  int n_err;
  int exp_g;

  rf_wb_arbiter #(.REG_LEN(32), .REG_BITS(5), .NUM_REQ(3)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in, used to observe the final value after ordered writes.
  always @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d,
                        input logic [1:0] g);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(1'b1));
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(a));
    chk({tag, "_wr_data"}, 64'(wr_data), 64'(d));
    chk({tag, "_grant_idx"}, 64'(grant_idx), 64'(g));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;

    // Reset state
    tick();
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_grant_idx", 64'(grant_idx), 64'(0));
    req_valid = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    #1 chk("rst_ready_ptr", 64'(req_ready), 64'(3'b001));
    tick();
    chk("rst_no_xfer", 64'(wr_en), 64'(0));
    reset = 1'b0;
    req_valid = 3'b000;
    #1 chk("idle_ready", 64'(req_ready), 64'(3'b000));
    tick();
    chk("idle_wr_en", 64'(wr_en), 64'(0));

    // Three requesters at once
    req_valid = 3'b111;
    #1 chk("rr_ready0", 64'(req_ready), 64'(3'b001));
    tick();
    chk_wr("rr_w0", 5'd1, 32'hAAAA_0001, 2'd0);
    req_valid = 3'b110;
    #1 chk("rr_ready1", 64'(req_ready), 64'(3'b010));
    tick();
    chk_wr("rr_w1", 5'd2, 32'hBBBB_0002, 2'd1);
    req_valid = 3'b100;
    #1 chk("rr_ready2", 64'(req_ready), 64'(3'b100));
    tick();
    chk_wr("rr_w2", 5'd3, 32'hCCCC_0003, 2'd2);
    req_valid = 3'b000;
    tick();
    chk("hold_wr_en", 64'(wr_en), 64'(0));
    chk("hold_wr_addr", 64'(wr_addr), 64'(5'd3));
    chk("hold_wr_data", 64'(wr_data), 64'(32'hCCCC_0003));

    // Single requester 1
    req_valid = 3'b010;
    req_addr = {5'd0, 5'd5, 5'd0};
    req_data = {32'h0, 32'hDEAD_BEEF, 32'h0};
    #1 chk("single_ready", 64'(req_ready), 64'(3'b010));
    tick();
    chk_wr("single", 5'd5, 32'hDEAD_BEEF, 2'd1);

    // Write to x0 is accepted but suppressed
    req_valid = 3'b100;
    req_addr = {5'd0, 5'd0, 5'd0};
    req_data = {32'h0000_1234, 32'h0, 32'h0};
    #1 chk("x0_ready", 64'(req_ready), 64'(3'b100));
    tick();
    chk("x0_wr_en", 64'(wr_en), 64'(0));
    chk("x0_grant_idx", 64'(grant_idx), 64'(2'd2));

    // Requesters 0 and 2 continuously valid: alternate starting at 0
    req_valid = 3'b101;
    req_addr = {5'd12, 5'd0, 5'd10};
    req_data = {32'h0000_00C0, 32'h0, 32'h0000_00A0};
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 0 : 2;
      #1 chk("fair_ready", 64'(req_ready), (exp_g == 0) ? 64'(3'b001) : 64'(3'b100));
      tick();
      chk("fair_grant", 64'(grant_idx), 64'(exp_g));
      chk("fair_addr", 64'(wr_addr), (exp_g == 0) ? 64'(10) : 64'(12));
    end

    // Move pointer to 1, then reset in the cycle a transfer would be accepted
    req_valid = 3'b010;
    req_addr = {5'd0, 5'd4, 5'd0};
    req_data = {32'h0, 32'h0000_0044, 32'h0};
    #1 chk("pre_rst_ready", 64'(req_ready), 64'(3'b010));
    tick();
    chk_wr("pre_rst", 5'd4, 32'h0000_0044, 2'd1);
    req_valid = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    #1 chk("mid_ready", 64'(req_ready), 64'(3'b100));
    reset = 1'b1;
    #1;
    chk("async_wr_en", 64'(wr_en), 64'(0));
    chk("async_wr_addr", 64'(wr_addr), 64'(0));
    chk("async_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk("in_rst_wr_en", 64'(wr_en), 64'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("release_wr_en", 64'(wr_en), 64'(0));
    chk("release_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk_wr("post_rst", 5'd1, 32'hAAAA_0001, 2'd0);
    req_valid = 3'b000;
    tick();
    chk("post_rst_idle", 64'(wr_en), 64'(0));

    // Pointer to 2, then same-address writes from 0 and 1
    req_valid = 3'b100;
    req_addr = {5'd13, 5'd0, 5'd0};
    req_data = {32'h0000_0033, 32'h0, 32'h0};
    #1 chk("ptr2_ready", 64'(req_ready), 64'(3'b100));
    tick();
    chk_wr("ptr2", 5'd13, 32'h0000_0033, 2'd2);
    req_valid = 3'b011;
    req_addr = {5'd0, 5'd7, 5'd7};
    req_data = {32'h0, 32'h0000_0022, 32'h0000_0011};
    #1 chk("same_ready0", 64'(req_ready), 64'(3'b001));
    tick();
    chk_wr("same_w0", 5'd7, 32'h0000_0011, 2'd0);
    req_valid = 3'b010;
    #1 chk("same_ready1", 64'(req_ready), 64'(3'b010));
    tick();
    chk_wr("same_w1", 5'd7, 32'h0000_0022, 2'd1);
    req_valid = 3'b000;
    tick();
    chk("same_idle", 64'(wr_en), 64'(0));
    chk("same_final_rf7", 64'(rf[7]), 64'(32'h0000_0022));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
